// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
//   Shared constants and helpers for the demux block.
//   - DEMUX_*_DEF : default parameter values for demux.
//   - DEMUX_MAX_N : widest lane mask lane_mask() can build.
//   - lane_mask() : one-hot lane enable for a select value. It is all-zero
//                   when sel >= n_out and all-X when sel is unknown.
// ---------------------------------------------------------------------------
package demux_pkg;

   localparam int DEMUX_DATA_W_DEF = 1;
   localparam int DEMUX_SEL_W_DEF  = 2;
   localparam int DEMUX_N_OUT_DEF  = 4;

   // A package function cannot take its width from the caller's parameters.
   // It returns a fixed-width mask, and the caller truncates it to N_OUT bits.
   localparam int DEMUX_MAX_N      = 64;

   function automatic logic [DEMUX_MAX_N-1:0] lane_mask(input logic [31:0] sel,
                                                       input int          n_out);
      logic [DEMUX_MAX_N-1:0] mask;
      // A shift is used here instead of an if/case on sel. An unknown sel then
      // smears X across the mask instead of silently selecting nothing.
      mask = DEMUX_MAX_N'(1) << sel;
      for (int i = 0; i < DEMUX_MAX_N; i++) begin
         if (i >= n_out) begin
            mask[i] = 1'b0;
         end
      end
      return mask;
   endfunction

endpackage : demux_pkg

// File: rtl/demux_lane.sv
// ---------------------------------------------------------------------------
// demux_lane
//   One output lane of the demux. The lane passes in when en is high and
//   outputs zero otherwise.
//   Ports:
//     in   [DATA_W-1:0]  shared input data
//     en                 one-hot enable bit for this lane
//     out  [DATA_W-1:0]  gated lane data
// ---------------------------------------------------------------------------
module demux_lane #(
   parameter int DATA_W = 1
) (
   input  logic [DATA_W-1:0] in,
   input  logic              en,
   output logic [DATA_W-1:0] out
);

   // NOTE: continuous AND gating has no branches, so no path can leave out
   //       unassigned and a latch cannot be inferred.
   assign out = in & {DATA_W{en}};

endmodule : demux_lane

// File: rtl/demux.sv
// ---------------------------------------------------------------------------
// demux
//   Parameterised 1-to-N demultiplexer. The design routes in to lane sel of
//   out and drives every other lane to zero. When sel >= N_OUT, all lanes are
//   zero. out is purely combinational and does not depend on rst_n. out_q and
//   sel_err_q are copies of out and of the out-of-range condition, delayed by
//   one cycle and cleared asynchronously.
//
//   Parameters: DATA_W (lane width), SEL_W (sel width),
//               N_OUT (lane count, 2..2**SEL_W)
//   Ports:
//     clk        rising-edge clock for the registered outputs
//     rst_n      asynchronous active-low reset (registered outputs only)
//     in         [DATA_W-1:0]        data to route
//     sel        [SEL_W-1:0]         lane index
//     out        [N_OUT*DATA_W-1:0]  combinational lanes, lane k at [k*DATA_W +: DATA_W]
//     out_q      [N_OUT*DATA_W-1:0]  out registered
//     sel_err_q                      (sel >= N_OUT) registered
//
//   Optional build macro: DEMUX_ONEHOT_ASSERT_EN adds simulation-only
//   concurrent checks. The checks cover the one-hot property of out,
//   out_q tracking out, and a known sel while out of reset.
// ---------------------------------------------------------------------------
module demux
   import demux_pkg::*;
#(
   parameter int DATA_W = DEMUX_DATA_W_DEF,
   parameter int SEL_W  = DEMUX_SEL_W_DEF,
   parameter int N_OUT  = DEMUX_N_OUT_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_W-1:0]       in,
   input  logic [SEL_W-1:0]        sel,
   output logic [N_OUT*DATA_W-1:0] out,
   output logic [N_OUT*DATA_W-1:0] out_q,
   output logic                    sel_err_q
);

   // Elaboration guard on the lane count.
   if (N_OUT < 2 || N_OUT > 2**SEL_W || N_OUT > DEMUX_MAX_N) begin : g_bad_n_out
      $fatal(1, "demux: N_OUT=%0d illegal for SEL_W=%0d", N_OUT, SEL_W);
   end

   logic [N_OUT-1:0] lane_en;
   logic             sel_err;

   assign lane_en = N_OUT'(lane_mask(32'(sel), N_OUT));

   // The compare is widened by one bit so that N_OUT == 2**SEL_W still fits.
   // In that case the flag can never be set.
   assign sel_err = ({1'b0, sel} >= (SEL_W+1)'(N_OUT));

   for (genvar k = 0; k < N_OUT; k++) begin : g_lane
      demux_lane #(
         .DATA_W (DATA_W)
      ) u_lane (
         .in  (in),
         .en  (lane_en[k]),
         .out (out[k*DATA_W +: DATA_W])
      );
   end

   // NOTE: state registers use non-blocking assignments and an async
   //       active-low clear in the sensitivity list. The clear therefore
   //       acts at once, without waiting for a clk edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q     <= '0;
         sel_err_q <= 1'b0;
      end else begin
         out_q     <= out;
         sel_err_q <= sel_err;
      end
   end

`ifdef DEMUX_ONEHOT_ASSERT_EN
   logic [N_OUT-1:0] lane_nz;

   for (genvar k = 0; k < N_OUT; k++) begin : g_nz
      assign lane_nz[k] = |out[k*DATA_W +: DATA_W];
   end

   a_onehot : assert property (@(posedge clk) $onehot0(lane_nz))
      else $error("demux: multiple lanes active, sel=%0h out=%0h", sel, out);

   // Both edges must see rst_n high. An edge that follows a reset carries
   // no valid history for out_q.
   a_reg_track : assert property (@(posedge clk)
                                  (rst_n && $past(rst_n)) |-> (out_q == $past(out)))
      else $error("demux: out_q != previous out, sel=%0h out=%0h out_q=%0h",
                  sel, out, out_q);

   a_sel_known : assert property (@(posedge clk) rst_n |-> !$isunknown(sel))
      else $error("demux: unknown sel while out of reset, sel=%0h out=%0h", sel, out);
`else
`endif

endmodule : demux

// File: tb/tb_demux.sv
// ---------------------------------------------------------------------------
// tb_demux
//   Directed bench for demux with three configurations:
//     u_dut  : defaults (DATA_W=1, SEL_W=2, N_OUT=4)
//     u_dut3 : N_OUT=3, so sel=3 is out of range
//     u_dut8 : DATA_W=8, N_OUT=4
//   Inputs change on the falling edge. Combinational outputs are sampled 1 ns
//   after each input change, and registered outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_demux;

   logic        clk;
   logic        rst_n;

   logic        in1;
   logic [1:0]  sel1;
   logic [3:0]  out1, out_q1;
   logic        err_q1;

   logic        in3;
   logic [1:0]  sel3;
   logic [2:0]  out3, out_q3;
   logic        err_q3;

   logic [7:0]  in8;
   logic [1:0]  sel8;
   logic [31:0] out8, out_q8;
   logic        err_q8;

   int n_vec;
   int n_err;

   demux u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in1),
      .sel       (sel1),
      .out       (out1),
      .out_q     (out_q1),
      .sel_err_q (err_q1)
   );

   demux #(.DATA_W(1), .SEL_W(2), .N_OUT(3)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in3),
      .sel       (sel3),
      .out       (out3),
      .out_q     (out_q3),
      .sel_err_q (err_q3)
   );

   demux #(.DATA_W(8), .SEL_W(2), .N_OUT(4)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in8),
      .sel       (sel8),
      .out       (out8),
      .out_q     (out_q8),
      .sel_err_q (err_q8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "tb_demux watchdog");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      in1 = 1'b1; sel1 = 2'd0;
      in3 = 1'b0; sel3 = 2'd0;
      in8 = 8'h00; sel8 = 2'd0;

      // Reset state. The combinational path is already live during reset.
      #2;
      check("rst out_q1",    32'(out_q1), 32'h0);
      check("rst err_q1",    32'(err_q1), 32'h0);
      check("rst out1 live", 32'(out1),   32'h1);
      @(posedge clk); #1;
      check("rst held out_q1", 32'(out_q1), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Walking select with in=1. Each step is held for one 10 ns period.
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         in1 = 1'b1; sel1 = 2'(s);
         #1;
         check($sformatf("walk out1 sel=%0d", s), 32'(out1), 32'(4'b0001 << s));
         @(posedge clk); #1;
         check($sformatf("walk out_q1 sel=%0d", s), 32'(out_q1), 32'(4'b0001 << s));
         check($sformatf("walk err_q1 sel=%0d", s), 32'(err_q1), 32'h0);
      end

      // in=0 gives all-zero lanes for every valid sel.
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         in1 = 1'b0; sel1 = 2'(s);
         #1;
         check($sformatf("zero out1 sel=%0d", s), 32'(out1), 32'h0);
         @(posedge clk); #1;
         check($sformatf("zero out_q1 sel=%0d", s), 32'(out_q1), 32'h0);
         check($sformatf("zero err_q1 sel=%0d", s), 32'(err_q1), 32'h0);
      end

      // N_OUT=3: sel=3 is out of range. It recovers on sel=2 and then sel=0.
      @(negedge clk);
      in3 = 1'b1; sel3 = 2'd3;
      #1;
      check("n3 oor out3", 32'(out3), 32'h0);
      @(posedge clk); #1;
      check("n3 oor err_q3", 32'(err_q3), 32'h1);
      check("n3 oor out_q3", 32'(out_q3), 32'h0);
      @(negedge clk);
      sel3 = 2'd2;
      #1;
      check("n3 sel2 out3", 32'(out3), 32'h4);
      check("n3 sel2 err_q3 still", 32'(err_q3), 32'h1);
      @(posedge clk); #1;
      check("n3 sel2 err_q3", 32'(err_q3), 32'h0);
      check("n3 sel2 out_q3", 32'(out_q3), 32'h4);
      @(negedge clk);
      sel3 = 2'd0;
      #1;
      check("n3 sel0 out3", 32'(out3), 32'h1);

      // DATA_W=8: lane placement across the full vector.
      @(negedge clk);
      in8 = 8'hA5; sel8 = 2'd2;
      #1;
      check("w8 sel2 out8", out8, 32'h00A5_0000);
      @(posedge clk); #1;
      check("w8 sel2 out_q8", out_q8, 32'h00A5_0000);
      check("w8 err_q8", 32'(err_q8), 32'h0);
      @(negedge clk);
      sel8 = 2'd3;
      #1;
      check("w8 sel3 out8", out8, 32'hA500_0000);
      @(negedge clk);
      in8 = 8'h3C; sel8 = 2'd0;
      #1;
      check("w8 sel0 out8", out8, 32'h0000_003C);

      // Async reset mid-stream. Registers clear without a clock edge, and the
      // combinational lanes keep following in and sel.
      @(negedge clk);
      in1 = 1'b1; sel1 = 2'd1;
      sel3 = 2'd3;
      @(posedge clk); #1;
      check("pre-rst out_q1", 32'(out_q1), 32'h2);
      check("pre-rst err_q3", 32'(err_q3), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst out_q1", 32'(out_q1), 32'h0);
      check("async rst err_q3", 32'(err_q3), 32'h0);
      check("async rst out_q8", out_q8, 32'h0);
      check("async rst out1 live", 32'(out1), 32'h2);
      @(posedge clk); #1;
      check("rst edge out_q1", 32'(out_q1), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release out_q1 no edge", 32'(out_q1), 32'h0);
      @(posedge clk); #1;
      check("release out_q1", 32'(out_q1), 32'h2);
      check("release err_q3", 32'(err_q3), 32'h1);
      check("release out_q8", out_q8, 32'h0000_003C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_demux
